// File: rtl/fetch_unit_if.sv
// Decoder-side handshake between the fetch stage and the decoder.
// The fetch unit drives the code word and its PC; the decoder drives ready.
interface fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int CODE_W = 11
);
  logic [CODE_W-1:0] code;
  logic [ADDR_W-1:0] code_pc;
  logic              code_valid;
  logic              code_ready;

  modport master (output code, output code_pc, output code_valid, input code_ready);
  modport slave  (input code, input code_pc, input code_valid, output code_ready);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction
// memory, buffers returned words in a 2-entry FIFO and hands them to the
// decoder over a valid/ready handshake. Supports jump redirects and a
// sticky halt.
module fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                CODE_W   = 11,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [CODE_W-1:0] imem_code,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt,
  fetch_unit_if.master      dec,
  output logic              halted
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic [1:0]        occ;
  logic              rd_ptr, wr_ptr;
  logic [CODE_W-1:0] fifo_code [2];
  logic [ADDR_W-1:0] fifo_pc   [2];

  logic              head_valid;
  logic              xfer;
  logic              do_redirect;
  logic              issue;
  logic              push;
  logic [2:0]        demand;

  assign head_valid = (occ != 2'd0);
  assign xfer       = head_valid & dec.code_ready;
  assign demand     = {1'b0, occ} + {2'b00, inflight};
  // A redirect in the same cycle as a returning word kills that word.
  assign push       = inflight & ~do_redirect;

  // Next state, redirect acceptance and the issue decision; redirect and halt beat issuing.
  always_comb begin
    state_next  = state;
    do_redirect = 1'b0;
    issue       = 1'b0;
    case (state)
      IDLE: state_next = RUN;
      RUN: begin
        do_redirect = redirect;
        issue       = !redirect && !halt && (demand <= (3'd1 + {2'b00, xfer}));
        if (halt) state_next = HALTED;
      end
      HALTED: state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  // State register; HALTED is only left through reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // PC, outstanding-fetch tracking and FIFO pointers/occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      occ         <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= pc;
      if (do_redirect)  pc <= redirect_addr;
      else if (issue)   pc <= pc + ADDR_W'(1);
      if (do_redirect) begin
        occ    <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (xfer) rd_ptr <= ~rd_ptr;
        case ({push, xfer})
          2'b10:   occ <= occ + 2'd1;
          2'b01:   occ <= occ - 2'd1;
          default: occ <= occ;
        endcase
      end
    end
  end

  // FIFO storage; contents only matter while occupancy marks them valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_code[wr_ptr] <= imem_code;
      fifo_pc[wr_ptr]   <= inflight_pc;
    end
  end

  assign imem_en        = issue;
  assign imem_addr      = pc;
  assign dec.code_valid = head_valid;
  assign dec.code       = head_valid ? fifo_code[rd_ptr] : '0;
  assign dec.code_pc    = head_valid ? fifo_pc[rd_ptr]   : '0;
  assign halted         = (state == HALTED) && (occ == 2'd0) && !inflight;

endmodule
